// File: rtl/sram_ctrl_param.sv
// Asynchronous SRAM controller with configurable read/write wait states.
// Build option: define SRAM_IDLE_CE_EN to deassert ce_n while idle (otherwise ce_n is tied low).
module sram_ctrl_param #(
    parameter int  ADDR_W  = 20,
    parameter int  DATA_W  = 16,
    parameter int  RD_WAIT = 1,
    parameter int  WR_WAIT = 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] ad,
    output logic              we_n,
    output logic              oe_n,
    output logic              ce_n,
    output logic [BE_W-1:0]   be_n,
    inout  wire  [DATA_W-1:0] dio
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WR_HOLD = 2'd3
    } state_e;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT);
    localparam logic [3:0] WR_LAST = 4'(WR_WAIT);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ad_q, ad_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic                dio_oe_q, dio_oe_d;
    logic                ready_q, ready_d;
    logic                accept_s;

    // ready_q is only high in states that may take a new request, so accept implies launch
    assign accept_s = req & ready_q;

    // Next-state, wait counter and read-data capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = rw ? ST_RD : ST_WR;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d  = dio;
                    rvalid_d = 1'b1;
                    if (accept_s) begin
                        state_d = rw ? ST_RD : ST_WR;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WR: begin
                if (cnt_q == WR_LAST) begin
                    state_d = ST_WR_HOLD;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WR_HOLD: begin
                if (accept_s) begin
                    state_d = rw ? ST_RD : ST_WR;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Transaction attributes are captured once at accept and held until the next accept
    always_comb begin
        if (accept_s) begin
            ad_d    = addr;
            be_n_d  = ~be;
            wdata_d = wdata;
        end else begin
            ad_d    = ad_q;
            be_n_d  = be_n_q;
            wdata_d = wdata_q;
        end
    end

    // SRAM strobes and ready decoded from the next state so the registered pins never glitch
    always_comb begin
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        dio_oe_d = 1'b0;
        ready_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_RD: begin
                oe_n_d  = 1'b0;
                ready_d = (cnt_d == RD_LAST);
            end
            ST_WR: begin
                we_n_d   = 1'b0;
                dio_oe_d = 1'b1;
            end
            ST_WR_HOLD: begin
                dio_oe_d = 1'b1;
                ready_d  = 1'b1;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // Controller state and registered SRAM-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ad_q     <= {ADDR_W{1'b0}};
            be_n_q   <= {BE_W{1'b1}};
            wdata_q  <= {DATA_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            rvalid_q <= 1'b0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            dio_oe_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ad_q     <= ad_d;
            be_n_q   <= be_n_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            dio_oe_q <= dio_oe_d;
            ready_q  <= ready_d;
        end
    end

`ifdef SRAM_IDLE_CE_EN
    logic ce_n_q, ce_n_d;

    assign ce_n_d = (state_d == ST_IDLE);

    // Chip enable follows the same look-ahead timing as oe_n/we_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ce_n_q <= 1'b1;
        end else begin
            ce_n_q <= ce_n_d;
        end
    end

    assign ce_n = ce_n_q;
`else
    assign ce_n = 1'b0;
`endif

    assign ready  = ready_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ad     = ad_q;
    assign we_n   = we_n_q;
    assign oe_n   = oe_n_q;
    assign be_n   = be_n_q;
    assign dio    = dio_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Randomized bench for sram_ctrl_param: cycle timeline reference model plus a second
// instance (32-bit, RD_WAIT=0, WR_WAIT=3) exercised with a directed write/read.
module tb_sram_ctrl_param;

    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int BW   = 2;
    localparam int RDW  = 1;
    localparam int WRW  = 1;
    localparam int MAXC = 4096;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          req, rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          ready, rvalid, we_n, oe_n, ce_n;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ad;
    logic [BW-1:0] be_n;
    wire  [DW-1:0] dio;

    logic          req2, rw2;
    logic [AW-1:0] addr2;
    logic [31:0]   wdata2;
    logic [3:0]    be2;
    logic          ready2, rvalid2, we_n2, oe_n2, ce_n2;
    logic [31:0]   rdata2;
    logic [AW-1:0] ad2;
    logic [3:0]    be_n2;
    wire  [31:0]   dio2;

    sram_ctrl_param u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .ad(ad), .we_n(we_n), .oe_n(oe_n),
        .ce_n(ce_n), .be_n(be_n), .dio(dio)
    );

    sram_ctrl_param #(.ADDR_W(20), .DATA_W(32), .RD_WAIT(0), .WR_WAIT(3)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .rw(rw2), .addr(addr2), .wdata(wdata2), .be(be2),
        .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .ad(ad2), .we_n(we_n2), .oe_n(oe_n2),
        .ce_n(ce_n2), .be_n(be_n2), .dio(dio2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (en[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] fill(input int a);
        return (32'(a) + 32'd1) * 32'h9E3779B9 ^ 32'h5A5AC3C3;
    endfunction

    // SRAM model for the default instance (low 8 address bits decoded)
    logic [DW-1:0] mem1 [0:255];
    bit            wr1  [0:255];
    logic [7:0]    idx1;
    logic [DW-1:0] rd1;
    assign idx1 = ad[7:0];
    always_comb rd1 = wr1[idx1] ? mem1[idx1] : 16'(fill(int'(idx1)));
    assign dio = (!oe_n) ? rd1 : {DW{1'bz}};
    always @(posedge clk) begin
        if (!we_n) begin
            mem1[idx1] <= 16'(merge({16'h0, rd1}, {16'h0, dio}, {2'b00, ~be_n}));
            wr1[idx1]  <= 1'b1;
        end
    end

    // SRAM model for the 32-bit instance (low 4 address bits decoded)
    logic [31:0] mem2 [0:15];
    bit          wr2  [0:15];
    logic [3:0]  idx2;
    logic [31:0] rd2;
    assign idx2 = ad2[3:0];
    always_comb rd2 = wr2[idx2] ? mem2[idx2] : fill(int'(idx2));
    assign dio2 = (!oe_n2) ? rd2 : {32{1'bz}};
    always @(posedge clk) begin
        if (!we_n2) begin
            mem2[idx2] <= merge(rd2, dio2, ~be_n2);
            wr2[idx2]  <= 1'b1;
        end
    end

    // Reference model: expected pin values per cycle, filled in when a request is accepted
    bit            e_oe_n [MAXC];
    bit            e_we_n [MAXC];
    bit            e_ready[MAXC];
    bit            e_rvalid[MAXC];
    bit            e_busy [MAXC];
    bit            e_drv  [MAXC];
    logic [DW-1:0] e_rdata[MAXC];
    logic [DW-1:0] e_wdata[MAXC];
    logic [AW-1:0] e_ad   [MAXC];
    logic [BW-1:0] e_be_n [MAXC];
    logic [DW-1:0] shadow [0:255];

    txn_t q[$];
    txn_t cur;
    bit   cur_v = 1'b0;

    task automatic clear_model();
        for (int c = 0; c < MAXC; c++) begin
            e_oe_n[c] = 1'b1; e_we_n[c] = 1'b1; e_ready[c] = 1'b1; e_rvalid[c] = 1'b0;
            e_busy[c] = 1'b0; e_drv[c] = 1'b0; e_rdata[c] = 16'h0; e_wdata[c] = 16'h0;
            e_ad[c] = 20'h0; e_be_n[c] = 2'b11;
        end
    endtask

    task automatic model_accept(input int c, input txn_t t);
        int s;
        int n;
        s = c + 1;
        if (t.rw) begin
            n = RDW + 1;
            for (int k = 0; k < n; k++) begin
                e_oe_n[s+k] = 1'b0; e_ready[s+k] = (k == n - 1); e_busy[s+k] = 1'b1;
                e_ad[s+k] = t.addr; e_be_n[s+k] = ~t.be;
            end
            e_rvalid[s+n] = 1'b1;
            e_rdata[s+n]  = shadow[t.addr[7:0]];
        end else begin
            n = WRW + 2;
            for (int k = 0; k < n; k++) begin
                e_we_n[s+k] = (k == n - 1); e_ready[s+k] = (k == n - 1); e_busy[s+k] = 1'b1;
                e_drv[s+k] = 1'b1; e_wdata[s+k] = t.wdata; e_ad[s+k] = t.addr; e_be_n[s+k] = ~t.be;
            end
            shadow[t.addr[7:0]] = 16'(merge({16'h0, shadow[t.addr[7:0]]}, {16'h0, t.wdata}, {2'b00, t.be}));
        end
    endtask

    task automatic check_cycle(input int c);
        check("oe_n", oe_n, e_oe_n[c]);
        check("we_n", we_n, e_we_n[c]);
        check("ready", ready, e_ready[c]);
        check("rvalid", rvalid, e_rvalid[c]);
        check("we_oe_excl", we_n | oe_n, 1'b1);
`ifdef SRAM_IDLE_CE_EN
        check("ce_n", ce_n, !e_busy[c]);
`else
        check("ce_n", ce_n, 1'b0);
`endif
        if (e_busy[c]) begin
            check("ad", ad, e_ad[c]);
            check("be_n", be_n, e_be_n[c]);
        end
        if (e_rvalid[c]) check("rdata", rdata, e_rdata[c]);
        if (e_drv[c]) check("dio_wr", dio, e_wdata[c]);
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle(cyc);
        if (!cur_v && q.size() > 0) begin
            cur   = q.pop_front();
            cur_v = 1'b1;
        end
        if (cur_v) begin
            req = 1'b1; rw = cur.rw; addr = cur.addr; wdata = cur.wdata; be = cur.be;
        end else begin
            req = 1'b0; rw = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom); be = BW'($urandom);
        end
        if (cur_v && ready) begin
            model_accept(cyc, cur);
            cur_v = 1'b0;
        end
        cyc++;
    endtask

    function automatic txn_t mk(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [BW-1:0] b);
        txn_t t;
        t.rw = r; t.addr = a; t.wdata = d; t.be = b;
        return t;
    endfunction

    initial begin
        int we_cnt, oe_cnt, rv_cnt, oe_at, rv_at;
        logic [31:0] exp2;
        reset_n = 1'b0; req = 1'b0; rw = 1'b0; addr = 20'h0; wdata = 16'h0; be = 2'b00;
        req2 = 1'b0; rw2 = 1'b0; addr2 = 20'h0; wdata2 = 32'h0; be2 = 4'h0;
        clear_model();
        for (int a = 0; a < 256; a++) shadow[a] = 16'(fill(a));

        repeat (2) @(negedge clk);
        check("rst_we_n", we_n, 1'b1);
        check("rst_oe_n", oe_n, 1'b1);
        check("rst_be_n", be_n, 2'b11);
        check("rst_ad", ad, 20'h0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_rvalid", rvalid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        q.push_back(mk(1'b0, 20'h00010, 16'hA55A, 2'b11));
        repeat (6) step();
        q.push_back(mk(1'b1, 20'h00010, 16'h0000, 2'b11));
        repeat (6) step();
        q.push_back(mk(1'b0, 20'h00001, 16'h1E2D, 2'b11));
        q.push_back(mk(1'b1, 20'h00001, 16'h0000, 2'b11));
        q.push_back(mk(1'b1, 20'h00002, 16'h0000, 2'b01));
        q.push_back(mk(1'b0, 20'h00003, 16'hFFFF, 2'b00));
        q.push_back(mk(1'b1, 20'h00003, 16'h0000, 2'b10));
        repeat (20) step();

        repeat (1500) begin
            if (q.size() < 2 && $urandom_range(0, 2) != 0)
                q.push_back(mk(1'($urandom), AW'($urandom) & 20'hF000F, DW'($urandom), BW'($urandom)));
            step();
        end
        for (int i = 0; i < 100 && (cur_v || q.size() > 0); i++) step();
        check("drain_timeout", cur_v || q.size() > 0, 1'b0);
        repeat (6) step();

        // Reset pulled in the second write-pulse cycle, then read the same word back
        q.push_back(mk(1'b0, 20'h00020, 16'h1234, 2'b11));
        for (int i = 0; i < 20 && (cur_v || q.size() > 0); i++) step();
        check("rst_accept_timeout", cur_v || q.size() > 0, 1'b0);
        step();
        @(negedge clk);
        check_cycle(cyc);
        req = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("abort_we_n", we_n, 1'b1);
        check("abort_oe_n", oe_n, 1'b1);
        check("abort_rvalid", rvalid, 1'b0);
        check("abort_be_n", be_n, 2'b11);
        check("abort_ad", ad, 20'h0);
        @(negedge clk);
        check("abort_rvalid_hold", rvalid, 1'b0);
        reset_n = 1'b1;
        clear_model();
        cyc = 0;
        cur_v = 1'b0;
        q.push_back(mk(1'b1, 20'h00020, 16'h0000, 2'b11));
        repeat (8) step();

        // 32-bit instance: RD_WAIT=0, WR_WAIT=3
        @(negedge clk);
        check("d2_ready_idle", ready2, 1'b1);
`ifdef SRAM_IDLE_CE_EN
        check("d2_ce_n_idle", ce_n2, 1'b1);
`else
        check("d2_ce_n_idle", ce_n2, 1'b0);
`endif
        req2 = 1'b1; rw2 = 1'b0; addr2 = 20'h5; wdata2 = 32'h12345678; be2 = 4'b0101;
        @(negedge clk);
        req2 = 1'b0;
        we_cnt = 0;
        oe_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (!we_n2) begin
                we_cnt++;
                check("d2_be_n", be_n2, 4'b1010);
                check("d2_dio", dio2, 32'h12345678);
                check("d2_ad", ad2, 20'h5);
            end
            if (!oe_n2) oe_cnt++;
            @(negedge clk);
        end
        check("d2_we_len", we_cnt, 4);
        check("d2_oe_len_w", oe_cnt, 0);
        req2 = 1'b1; rw2 = 1'b1; addr2 = 20'h5; be2 = 4'hF;
        @(negedge clk);
        req2 = 1'b0;
        exp2 = merge(fill(5), 32'h12345678, 4'b0101);
        oe_cnt = 0; rv_cnt = 0; oe_at = -1; rv_at = -1;
        for (int i = 0; i < 6; i++) begin
            if (!oe_n2) begin
                oe_cnt++;
                oe_at = i;
            end
            if (rvalid2) begin
                rv_cnt++;
                rv_at = i;
                check("d2_rdata", rdata2, exp2);
            end
            @(negedge clk);
        end
        check("d2_oe_len", oe_cnt, 1);
        check("d2_oe_at", oe_at, 0);
        check("d2_rv_cnt", rv_cnt, 1);
        check("d2_rv_at", rv_at, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
